// File: rtl/segment_capture_pkg.sv
// Shared constants and types for the seven-segment capture block:
// digit count, glyph table, FSM state type and anode helpers.
package segment_capture_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 2;
  localparam int NUM_GLYPHS = 16;

  // Active-low glyph bytes with dp off; index = hex value
  localparam logic [NUM_GLYPHS-1:0][7:0] GLYPH_TBL = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_e;

  function automatic logic anode_onehot_low(input logic [NUM_DIGITS-1:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an[i]) zeros++;
    return (zeros == 1);
  endfunction

  function automatic logic [DIG_W-1:0] anode_index(input logic [NUM_DIGITS-1:0] an);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an[i]) idx = DIG_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/segment_to_hex.sv
// Combinational decode of an active-low 7-segment pattern {g..a} to a hex nibble.
module segment_to_hex
  import segment_capture_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      if (segment == GLYPH_TBL[g][6:0]) begin
        nibble = 4'(g);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_capture.sv
// Snoops a multiplexed 4-digit 7-segment bus and rebuilds the displayed hex frame.
// Optional decimal-point capture is enabled with `define SEGMENT_CAPTURE_DP_EN.
module segment_capture
  import segment_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [7:0]              segment,
  output logic [NUM_DIGITS*4-1:0] dataOut,
  output logic [NUM_DIGITS-1:0]   digitPoint,
  output logic                    frameValid,
  output logic                    decodeError
);

  logic [NUM_DIGITS-1:0]      anode_q, anode_prev_q;
  logic [7:0]                 seg_q, seg_prev_q;
  cap_state_e                 state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] shadow_q;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic [NUM_DIGITS*4-1:0]    data_q;
  logic                       fv_q, err_q;

  logic             changed, one_hot, settled, sample_en, frame_done;
  logic [DIG_W-1:0] dig_idx;
  logic [3:0]       dec_nib;
  logic             dec_valid;

  // Input stage plus a one-cycle history for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q      <= '1;
      seg_q        <= '1;
      anode_prev_q <= '1;
      seg_prev_q   <= '1;
    end else begin
      anode_q      <= anode;
      seg_q        <= segment;
      anode_prev_q <= anode_q;
      seg_prev_q   <= seg_q;
    end
  end

  assign changed = (anode_q != anode_prev_q) || (seg_q != seg_prev_q);
  assign one_hot = anode_onehot_low(anode_q);
  assign settled = (cnt_q == 8'(SETTLE_CYCLES - 1));
  assign dig_idx = anode_index(anode_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (changed) begin
      cnt_d   = '0;
      state_d = one_hot ? ST_SETTLE : ST_IDLE;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (settled) state_d = ST_HELD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sample_en = 1'b0;
    if (state_q == ST_SETTLE && !changed && settled) sample_en = 1'b1;
  end

  segment_to_hex u_dec (
    .segment (seg_q[6:0]),
    .nibble  (dec_nib),
    .valid   (dec_valid)
  );

  assign frame_done = (seen_q == '1);

  // A completed frame clears seen first; a same-edge sample then re-marks its slot
  always_comb begin
    seen_d = frame_done ? '0 : seen_q;
    if (sample_en && dec_valid) seen_d[dig_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      seen_q   <= '0;
      data_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seen_q <= seen_d;
      fv_q   <= frame_done;
      if (frame_done) data_q <= shadow_q;
      if (sample_en && dec_valid) shadow_q[dig_idx] <= dec_nib;
      if (sample_en && !dec_valid) err_q <= 1'b1;
    end
  end

`ifdef SEGMENT_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_shadow_q <= '0;
      dp_q        <= '0;
    end else begin
      if (frame_done) dp_q <= dp_shadow_q;
      if (sample_en && dec_valid) dp_shadow_q[dig_idx] <= ~seg_q[7];
    end
  end

  assign digitPoint = dp_q;
`else
  assign digitPoint = '0;
`endif

  assign dataOut     = data_q;
  assign frameValid  = fv_q;
  assign decodeError = err_q;

endmodule

// File: tb/tb_segment_capture.sv
// Directed and random checks of segment_capture against a dwell-level reference model.
module tb_segment_capture;

  localparam int SETTLE = 4;
  localparam int TH     = SETTLE + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [7:0]  segment = 8'hFF;
  logic [15:0] dataOut;
  logic [3:0]  digitPoint;
  logic        frameValid, decodeError;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int stab_err = 0;
  logic [15:0] prev_data = '0;

  segment_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .anode(anode), .segment(segment),
    .dataOut(dataOut), .digitPoint(digitPoint),
    .frameValid(frameValid), .decodeError(decodeError)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (frameValid === 1'b1) fv_cnt++;
    if (!reset && frameValid !== 1'b1 && dataOut !== prev_data) stab_err++;
    prev_data = dataOut;
  end

  // Reference model: works on whole dwells of the raw bus
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0]  m_an;
  logic [7:0]  m_sg;
  int          m_run;
  logic [3:0]  m_nib [4];
  logic        m_dp  [4];
  logic [3:0]  m_seen, m_dpo;
  logic [15:0] m_out;
  logic        m_err;
  int          m_frames = 0;

  task automatic model_reset();
    m_an = 4'hF; m_sg = 8'hFF; m_run = 0;
    for (int k = 0; k < 4; k++) begin m_nib[k] = '0; m_dp[k] = 1'b0; end
    m_seen = '0; m_dpo = '0; m_out = '0; m_err = 1'b0;
  endtask

  task automatic model_dwell(input logic [3:0] an, input logic [7:0] sg, input int len);
    int old, zeros, idx;
    logic ok;
    logic [3:0] nib;
    if (an == m_an && sg == m_sg) begin
      old = m_run; m_run += len;
    end else begin
      old = 0; m_run = len; m_an = an; m_sg = sg;
    end
    zeros = 0; idx = 0;
    for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; idx = k; end
    if (zeros == 1 && old < TH && m_run >= TH) begin
      ok = 1'b0; nib = '0;
      for (int g = 0; g < 16; g++) if (sg[6:0] == glyph[g][6:0]) begin ok = 1'b1; nib = 4'(g); end
      if (ok) begin
        m_nib[idx] = nib;
        m_dp[idx] = ~sg[7];
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
          for (int k = 0; k < 4; k++) begin
            m_out[4*k +: 4] = m_nib[k];
`ifdef SEGMENT_CAPTURE_DP_EN
            m_dpo[k] = m_dp[k];
`else
            m_dpo[k] = 1'b0;
`endif
          end
          m_frames++;
          m_seen = '0;
        end
      end else m_err = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [7:0] sg, input int len);
    anode = an; segment = sg;
    model_dwell(an, sg, len);
    repeat (len) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; anode = 4'hF; segment = 8'hFF;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".frames"}, fv_cnt, m_frames);
    chk({tag, ".data"}, {16'h0, dataOut}, {16'h0, m_out});
    chk({tag, ".dp"}, {28'h0, digitPoint}, {28'h0, m_dpo});
    chk({tag, ".err"}, {31'h0, decodeError}, {31'h0, m_err});
  endtask

  logic [3:0] exp_dp;
  int sel;
  logic [3:0] r_an;
  logic [7:0] r_sg;

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst.data", {16'h0, dataOut}, 32'h0);
    chk("rst.dp", {28'h0, digitPoint}, 32'h0);
    chk("rst.fv", {31'h0, frameValid}, 32'h0);
    chk("rst.err", {31'h0, decodeError}, 32'h0);

    // Full frame 1,2,3,4
    dwell(4'hE, 8'hF9, 6); dwell(4'hD, 8'hA4, 6); dwell(4'hB, 8'hB0, 6); dwell(4'h7, 8'h99, 6);
    dwell(4'hF, 8'hFF, 4);
    chk("full.frames", fv_cnt, 1);
    chk("full.data", {16'h0, dataOut}, 32'h4321);
    chk("full.err", {31'h0, decodeError}, 32'h0);
    chk_model("full");

    // Short dwell on digit 0 blocks the frame
    do_reset();
    dwell(4'hE, 8'h92, 3); dwell(4'hD, 8'hA4, 6); dwell(4'hB, 8'hB0, 6); dwell(4'h7, 8'h99, 6);
    dwell(4'hF, 8'hFF, 4);
    chk("short.frames", fv_cnt, 1);
    chk("short.data", {16'h0, dataOut}, 32'h0);
    chk_model("short");

    // Unknown glyph, then a valid frame with sticky error
    do_reset();
    dwell(4'hB, 8'hFF, 6); dwell(4'hF, 8'hFF, 4);
    chk("bad.err", {31'h0, decodeError}, 32'h1);
    dwell(4'hE, 8'h88, 6); dwell(4'hD, 8'h83, 6); dwell(4'hB, 8'hC6, 6); dwell(4'h7, 8'hA1, 6);
    dwell(4'hF, 8'hFF, 4);
    chk("bad.frames", fv_cnt, 2);
    chk("bad.data", {16'h0, dataOut}, 32'hDCBA);
    chk("bad.sticky", {31'h0, decodeError}, 32'h1);
    chk_model("bad");

    // Decimal point on digit 3
    do_reset();
    dwell(4'hE, 8'hF9, 6); dwell(4'hD, 8'hA4, 6); dwell(4'hB, 8'hB0, 6); dwell(4'h7, 8'h00, 6);
    dwell(4'hF, 8'hFF, 4);
`ifdef SEGMENT_CAPTURE_DP_EN
    exp_dp = 4'b1000;
`else
    exp_dp = 4'b0000;
`endif
    chk("dp.frames", fv_cnt, 3);
    chk("dp.data", {16'h0, dataOut}, 32'h8321);
    chk("dp.dp", {28'h0, digitPoint}, {28'h0, exp_dp});
    chk_model("dp");

    // Reset after two digits discards them
    do_reset();
    dwell(4'hE, 8'h92, 6); dwell(4'hD, 8'h82, 6);
    do_reset();
    dwell(4'hF, 8'hFF, 4);
    chk("midrst.data0", {16'h0, dataOut}, 32'h0);
    chk("midrst.frames0", fv_cnt, 3);
    dwell(4'hE, 8'hF8, 6); dwell(4'hD, 8'h80, 6); dwell(4'hB, 8'h90, 6); dwell(4'h7, 8'hC0, 6);
    dwell(4'hF, 8'hFF, 4);
    chk("midrst.frames", fv_cnt, 4);
    chk("midrst.data", {16'h0, dataOut}, 32'h0987);
    chk_model("midrst");

    // Blanking and multi-low anode are ignored
    dwell(4'hF, 8'h80, 10); dwell(4'hC, 8'h80, 10); dwell(4'hF, 8'hFF, 4);
    chk("blank.frames", fv_cnt, 4);
    chk("blank.data", {16'h0, dataOut}, 32'h0987);
    chk("blank.err", {31'h0, decodeError}, 32'h0);
    chk_model("blank");

    // Random dwells against the model
    do_reset();
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: r_an = ~(4'b0001 << sel);
        4: r_an = 4'hF;
        5: r_an = 4'hC;
        6: r_an = 4'($urandom);
        default: r_an = 4'hE;
      endcase
      if ($urandom_range(0, 9) < 8) begin
        r_sg = glyph[$urandom_range(0, 15)];
        r_sg[7] = 1'($urandom);
      end else r_sg = 8'($urandom);
      dwell(r_an, r_sg, $urandom_range(1, 8));
    end
    dwell(4'hF, 8'hFF, 4);
    chk_model("rand");
    chk("stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segment_capture.md
SEGMENT_CAPTURE -- requirements
Module: segment_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: consecutive cycles the registered anode/segment pair must stay unchanged before a digit is sampled (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port anode, input, 4: active-low digit select; anode[i]=0 selects digit i.
REQ-005 SHALL have port segment, input, 8: active-low segments, bit order {dp,g,f,e,d,c,b,a}.
REQ-006 SHALL have port dataOut, output, 16: last complete frame; digit i in dataOut[4i+3:4i].
REQ-007 SHALL have port digitPoint, output, 4: dp state of each digit in the last complete frame, 1 = lit.
REQ-008 SHALL have port frameValid, output, 1: one-cycle pulse when dataOut/digitPoint update.
REQ-009 SHALL have port decodeError, output, 1: sticky flag for an unrecognised segment pattern.

Function
REQ-010 SHALL register anode and segment once before all other logic (input stage, 1 cycle).
REQ-011 SHALL run a state machine with states IDLE, SETTLE and HELD.
- IDLE: registered anode not exactly one bit low.
- SETTLE: one-hot-low anode seen, stability counter running.
- HELD: digit sampled for this dwell.
REQ-012 SHALL clear the stability counter and enter SETTLE (one-hot-low) or IDLE (otherwise) whenever registered anode or segment differs from the previous cycle's value.
REQ-013 SHALL sample the digit on the edge where the counter reaches SETTLE_CYCLES, enter HELD, and not sample again until anode or segment changes.
REQ-014 SHALL decode segment[6:0] as active-low hex glyphs: C0=0, F9=1, A4=2, B0=3, 99=4, 92=5, 82=6, F8=7, 80=8, 90=9, 88=A, 83=b, C6=C, A1=d, 86=E, 8E=F (listed as byte values with dp=1).
REQ-015 SHALL, on a valid sample, write the nibble and ~segment[7] into shadow slot i and set seen[i].
REQ-016 SHALL, on an unrecognised pattern, set decodeError and leave shadow slot i and seen[i] unchanged.
REQ-017 SHALL, on the edge after seen becomes 4'b1111, copy all shadows to dataOut/digitPoint atomically, pulse frameValid for 1 cycle, and clear seen.
REQ-018 SHALL overwrite shadow slot i without error if digit i is sampled again before the frame completes (latest value wins).
REQ-019 SHALL treat all-high anode (blanking) and multi-low anode as IDLE, with no sample and no error.
REQ-020 SHALL hold dataOut/digitPoint stable between frameValid pulses.

Reset
REQ-021 SHALL, when reset is asserted, produce the following on the next edge:
- dataOut=16'h0000, digitPoint=4'b0000, frameValid=0, decodeError=0;
- seen=0, shadows=0, counter=0, state IDLE, input registers=all ones.
REQ-022 SHALL, on reset asserted mid-dwell or mid-frame, discard the partial frame with no frameValid pulse.
REQ-023 SHALL clear decodeError only on reset.

Configuration
REQ-024 SHALL, with SEGMENT_CAPTURE_DP_EN defined, capture decimal points per REQ-015.
REQ-025 SHALL, without SEGMENT_CAPTURE_DP_EN, tie digitPoint to 4'b0000, exclude dp shadow storage, and decode segment[6:0] only (segment[7] ignored).

Structure
REQ-026 SHALL take the glyph constants, state enum type and digit-count constant (4) from package segment_capture_pkg.
REQ-027 SHALL contain one combinational sub-module segment_to_hex with ports segment[6:0] in, nibble[3:0] out, valid out.

Verification
REQ-028 SHALL cover a full frame with SETTLE_CYCLES=4:
- stimulus: anode 1110/1101/1011/0111, each held 6 cycles with glyphs 1, 2, 3, 4;
- response: one frameValid pulse, dataOut=16'h4321, decodeError=0.
REQ-029 SHALL cover a short dwell: digit 0 held 3 cycles -> no sample, no frameValid after the remaining 3 digits.
REQ-030 SHALL cover an unknown glyph: segment=8'hFF on digit 2 -> decodeError=1; a later valid frame with glyphs A, b, C, d -> dataOut=16'hDCBA, decodeError still 1.
REQ-031 SHALL cover decimal points with DP_EN: digit 3 segment=8'h00 (8 with dp lit) -> digitPoint=4'b1000, nibble 8.
REQ-032 SHALL cover reset mid-frame: reset after 2 digits captured, then 4 new digits -> exactly one frameValid pulse with only the new values; dataOut=0 before that pulse.
REQ-033 SHALL cover anode 1111 and 1100 held 10 cycles -> no sample, no error, outputs unchanged.
